memory_stage: RTL and testbench

- Memory-access pipeline stage between execute and writeback.
- Issues load/store transactions to the data-memory bus and aligns/extends load data.
- Registers all execute results into the *_mw signals consumed by writeback.
- Stalls the state machine while a bus transaction is outstanding.

---
 rtl/memory_stage_pkg.sv | 20 ++
 rtl/memory_stage_if.sv | 15 +
 rtl/memory_stage_align.sv | 49 ++++
 rtl/memory_stage.sv | 117 +++++++++++
 tb/tb_memory_stage.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// Shared opcode field positions, access-size encodings and FSM states for the memory stage.
package memory_stage_pkg;
  localparam int OPLEN = 8;

  localparam int MEM_EN_BIT       = 0;
  localparam int MEM_WE_BIT       = 1;
  localparam int MEM_SIZE_BIT_L   = 2;
  localparam int MEM_SIZE_BIT_M   = 3;
  localparam int MEM_UNSIGNED_BIT = 4;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_HOLD} mem_state_e;

  function automatic logic [1:0] op_size(input logic [OPLEN-1:0] op);
    return op[MEM_SIZE_BIT_M:MEM_SIZE_BIT_L];
  endfunction
endpackage

// File: rtl/memory_stage_if.sv
// Data-memory bus: request held until ack, read data valid in the ack cycle.
interface memory_stage_if #(parameter int XLEN = 32);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  input  dmem_ack, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  output dmem_ack, dmem_rdata);
endinterface

// File: rtl/memory_stage_align.sv
// Combinational store lane/byte-enable generator and load lane extractor/extender.
module mem_align
  import memory_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      st_size,
  input  logic [1:0]      st_a,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      st_be,
  output logic [XLEN-1:0] st_wdata,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  input  logic [1:0]      ld_a,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      MEM_SIZE_B: begin
        st_be    = 4'b0001 << st_a;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_SIZE_H: begin
        st_be    = 4'b0011 << {st_a[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Misaligned addresses fall onto the lane chosen by the upper address bits only.
  always_comb begin
    ld_byte = ld_rdata[{ld_a, 3'b000} +: 8];
    ld_half = ld_rdata[{ld_a[1], 4'b0000} +: 16];
    case (ld_size)
      MEM_SIZE_B: ld_data = ld_unsigned ? {{(XLEN-8){1'b0}}, ld_byte}
                                        : {{(XLEN-8){ld_byte[7]}}, ld_byte};
      MEM_SIZE_H: ld_data = ld_unsigned ? {{(XLEN-16){1'b0}}, ld_half}
                                        : {{(XLEN-16){ld_half[15]}}, ld_half};
      default:    ld_data = ld_rdata;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// Memory-access stage between execute and writeback; issues one bus access per memory phase.
// Optional MISALIGN_CHECK_EN adds misalign_err and suppresses misaligned bus accesses.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_memory,
  input  logic [OPLEN-1:0] decoded_op_em,
  input  logic [4:0]       rdsel_em,
  input  logic [XLEN-1:0]  next_pc_em,
  input  logic [XLEN-1:0]  alu_out_em,
  input  logic [XLEN-1:0]  rs2data_em,
  input  logic             jump_state_em,
  output logic [OPLEN-1:0] decoded_op_mw,
  output logic [4:0]       rdsel_mw,
  output logic [XLEN-1:0]  next_pc_mw,
  output logic [XLEN-1:0]  alu_out_mw,
  output logic             jump_state_mw,
  output logic [XLEN-1:0]  mem_out_mw,
  memory_stage_if.master   dmem,
  output logic             stall_memory
`ifdef MISALIGN_CHECK_EN
  ,
  output logic             misalign_err
`endif
);
  mem_state_e      state;
  logic [1:0]      a_q;
  logic            mem_en;
  logic            misaligned;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_data;

  assign mem_en = decoded_op_em[MEM_EN_BIT];

`ifdef MISALIGN_CHECK_EN
  assign misaligned = mem_en &&
                      ((op_size(decoded_op_em) == MEM_SIZE_H && alu_out_em[0]) ||
                       (op_size(decoded_op_em) == MEM_SIZE_W && alu_out_em[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign stall_memory = (state == ST_BUSY) ||
                        (state == ST_IDLE && phase_memory && mem_en && !misaligned);

  mem_align #(.XLEN(XLEN)) u_align (
    .st_size     (op_size(decoded_op_em)),
    .st_a        (alu_out_em[1:0]),
    .st_data     (rs2data_em),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_size     (op_size(decoded_op_mw)),
    .ld_unsigned (decoded_op_mw[MEM_UNSIGNED_BIT]),
    .ld_a        (a_q),
    .ld_rdata    (dmem.dmem_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      a_q             <= '0;
      decoded_op_mw   <= '0;
      rdsel_mw        <= '0;
      next_pc_mw      <= '0;
      alu_out_mw      <= '0;
      jump_state_mw   <= 1'b0;
      mem_out_mw      <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
`ifdef MISALIGN_CHECK_EN
      misalign_err    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (phase_memory) begin
          decoded_op_mw <= decoded_op_em;
          rdsel_mw      <= rdsel_em;
          next_pc_mw    <= next_pc_em;
          alu_out_mw    <= alu_out_em;
          jump_state_mw <= jump_state_em;
          mem_out_mw    <= '0;
          a_q           <= alu_out_em[1:0];
`ifdef MISALIGN_CHECK_EN
          misalign_err  <= misaligned;
`endif
          if (mem_en && !misaligned) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= decoded_op_em[MEM_WE_BIT];
            dmem.dmem_addr  <= {alu_out_em[XLEN-1:2], 2'b00};
            dmem.dmem_be    <= st_be;
            dmem.dmem_wdata <= st_wdata;
            state           <= ST_BUSY;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_BUSY: if (dmem.dmem_ack) begin
          mem_out_mw    <= ld_data;
          dmem.dmem_req <= 1'b0;
          state         <= ST_HOLD;
        end
        // Wait for the phase to drop so a long phase never issues twice.
        ST_HOLD: if (!phase_memory) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage; expected values are hand-computed constants.
module tb_memory_stage;
  import memory_stage_pkg::*;
  localparam int XLEN = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             phase_memory;
  logic [OPLEN-1:0] decoded_op_em;
  logic [4:0]       rdsel_em;
  logic [XLEN-1:0]  next_pc_em, alu_out_em, rs2data_em;
  logic             jump_state_em;
  logic [OPLEN-1:0] decoded_op_mw;
  logic [4:0]       rdsel_mw;
  logic [XLEN-1:0]  next_pc_mw, alu_out_mw, mem_out_mw;
  logic             jump_state_mw;
  logic             stall_memory;
`ifdef MISALIGN_CHECK_EN
  logic             misalign_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  memory_stage_if #(.XLEN(XLEN)) bus ();

  memory_stage #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .phase_memory  (phase_memory),
    .decoded_op_em (decoded_op_em),
    .rdsel_em      (rdsel_em),
    .next_pc_em    (next_pc_em),
    .alu_out_em    (alu_out_em),
    .rs2data_em    (rs2data_em),
    .jump_state_em (jump_state_em),
    .decoded_op_mw (decoded_op_mw),
    .rdsel_mw      (rdsel_mw),
    .next_pc_mw    (next_pc_mw),
    .alu_out_mw    (alu_out_mw),
    .jump_state_mw (jump_state_mw),
    .mem_out_mw    (mem_out_mw),
    .dmem          (bus),
    .stall_memory  (stall_memory)
`ifdef MISALIGN_CHECK_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OPLEN-1:0] mk_op(input bit en, input bit we,
                                             input logic [1:0] sz, input bit uns);
    logic [OPLEN-1:0] op;
    op = 8'h80;
    op[MEM_EN_BIT]       = en;
    op[MEM_WE_BIT]       = we;
    op[MEM_SIZE_BIT_M:MEM_SIZE_BIT_L] = sz;
    op[MEM_UNSIGNED_BIT] = uns;
    return op;
  endfunction

  task automatic launch(input logic [OPLEN-1:0] op, input logic [XLEN-1:0] addr,
                        input logic [XLEN-1:0] rs2);
    decoded_op_em = op;
    alu_out_em    = addr;
    rs2data_em    = rs2;
    phase_memory  = 1'b1;
    tick();
    phase_memory  = 1'b0;
  endtask

  // Acks on the current cycle, then lets HOLD return to IDLE.
  task automatic complete(input logic [XLEN-1:0] rdata);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = rdata;
    tick();
    bus.dmem_ack   = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_chk++;
    if ({decoded_op_mw, rdsel_mw, next_pc_mw, alu_out_mw, jump_state_mw, mem_out_mw} !== '0) begin
      n_fail++; $display("FAIL reset_mw got alu=%h mem=%h op=%h", alu_out_mw, mem_out_mw, decoded_op_mw);
    end
    n_chk++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, stall_memory} !== '0) begin
      n_fail++; $display("FAIL reset_bus got req=%b addr=%h be=%b stall=%b expected all 0",
                         bus.dmem_req, bus.dmem_addr, bus.dmem_be, stall_memory);
    end
`ifdef MISALIGN_CHECK_EN
    n_chk++;
    if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b expected 0", misalign_err); end
`endif
  endtask

  task automatic test_nonmem;
    decoded_op_em = 8'h80; alu_out_em = 32'h1234; rdsel_em = 5'd7;
    next_pc_em = 32'h44; jump_state_em = 1'b1; phase_memory = 1'b1;
    #1;
    n_chk++;
    if (stall_memory !== 1'b0) begin n_fail++; $display("FAIL nonmem_stall_pre got %b expected 0", stall_memory); end
    tick();
    phase_memory = 1'b0;
    n_chk++;
    if (alu_out_mw !== 32'h1234) begin n_fail++; $display("FAIL nonmem_alu got %h expected 00001234", alu_out_mw); end
    n_chk++;
    if ({rdsel_mw, next_pc_mw, jump_state_mw, decoded_op_mw} !== {5'd7, 32'h44, 1'b1, 8'h80}) begin
      n_fail++; $display("FAIL nonmem_fields got rd=%0d pc=%h j=%b op=%h expected 7 44 1 80",
                         rdsel_mw, next_pc_mw, jump_state_mw, decoded_op_mw);
    end
    n_chk++;
    if ({bus.dmem_req, stall_memory} !== 2'b00) begin
      n_fail++; $display("FAIL nonmem_req got req=%b stall=%b expected 0 0", bus.dmem_req, stall_memory);
    end
    tick();
    n_chk++;
    if ({bus.dmem_req, stall_memory} !== 2'b00) begin
      n_fail++; $display("FAIL nonmem_idle got req=%b stall=%b expected 0 0", bus.dmem_req, stall_memory);
    end
  endtask

  task automatic test_store;
    decoded_op_em = mk_op(1, 1, MEM_SIZE_B, 0); alu_out_em = 32'h103; rs2data_em = 32'hAB;
    phase_memory = 1'b1;
    #1;
    n_chk++;
    if (stall_memory !== 1'b1) begin n_fail++; $display("FAIL sb_stall_comb got %b expected 1", stall_memory); end
    tick();
    phase_memory = 1'b0;
    n_chk++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata} !==
        {1'b1, 1'b1, 32'h100, 4'b1000, 32'hABABABAB}) begin
      n_fail++; $display("FAIL sb_bus got req=%b we=%b addr=%h be=%b wdata=%h expected 1 1 00000100 1000 abababab",
                         bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({bus.dmem_req, stall_memory, bus.dmem_addr, bus.dmem_be} !== {2'b11, 32'h100, 4'b1000}) begin
        n_fail++; $display("FAIL sb_wait%0d got req=%b stall=%b addr=%h be=%b expected held",
                           i, bus.dmem_req, stall_memory, bus.dmem_addr, bus.dmem_be);
      end
    end
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    n_chk++;
    if ({bus.dmem_req, stall_memory} !== 2'b00) begin
      n_fail++; $display("FAIL sb_done got req=%b stall=%b expected 0 0", bus.dmem_req, stall_memory);
    end
    tick();
    launch(mk_op(1, 1, MEM_SIZE_H, 0), 32'h202, 32'h1234ABCD);
    n_chk++;
    if ({bus.dmem_be, bus.dmem_wdata} !== {4'b1100, 32'hABCDABCD}) begin
      n_fail++; $display("FAIL sh_bus got be=%b wdata=%h expected 1100 abcdabcd", bus.dmem_be, bus.dmem_wdata);
    end
    complete(32'h0);
    launch(mk_op(1, 1, MEM_SIZE_W, 0), 32'h300, 32'hDEADBEEF);
    n_chk++;
    if ({bus.dmem_addr, bus.dmem_be, bus.dmem_wdata} !== {32'h300, 4'b1111, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL sw_bus got addr=%h be=%b wdata=%h expected 00000300 1111 deadbeef",
                         bus.dmem_addr, bus.dmem_be, bus.dmem_wdata);
    end
    complete(32'h0);
  endtask

  task automatic test_load;
    launch(mk_op(1, 0, MEM_SIZE_B, 0), 32'h101, 32'h0);
    n_chk++;
    if ({bus.dmem_we, bus.dmem_be} !== {1'b0, 4'b0010}) begin
      n_fail++; $display("FAIL lb_bus got we=%b be=%b expected 0 0010", bus.dmem_we, bus.dmem_be);
    end
    complete(32'h0000F000);
    n_chk++;
    if (mem_out_mw !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb_data got %h expected fffffff0", mem_out_mw); end
    launch(mk_op(1, 0, MEM_SIZE_B, 1), 32'h101, 32'h0);
    complete(32'h0000F000);
    n_chk++;
    if (mem_out_mw !== 32'h000000F0) begin n_fail++; $display("FAIL lbu_data got %h expected 000000f0", mem_out_mw); end
    // Zero-wait bus: phase edge, then ack edge, then data is visible.
    launch(mk_op(1, 0, MEM_SIZE_H, 0), 32'h202, 32'h0);
    n_chk++;
    if ({bus.dmem_req, bus.dmem_be} !== {1'b1, 4'b1100}) begin
      n_fail++; $display("FAIL lh_bus got req=%b be=%b expected 1 1100", bus.dmem_req, bus.dmem_be);
    end
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h80010000;
    tick();
    bus.dmem_ack = 1'b0;
    n_chk++;
    if ({bus.dmem_req, mem_out_mw} !== {1'b0, 32'hFFFF8001}) begin
      n_fail++; $display("FAIL lh_latency got req=%b data=%h expected 0 ffff8001", bus.dmem_req, mem_out_mw);
    end
    tick();
    launch(mk_op(1, 0, MEM_SIZE_W, 0), 32'h200, 32'h0);
    complete(32'h80010000);
    n_chk++;
    if (mem_out_mw !== 32'h80010000) begin n_fail++; $display("FAIL lw_data got %h expected 80010000", mem_out_mw); end
  endtask

  task automatic test_reset_mid;
    rdsel_em = 5'd9; next_pc_em = 32'h88; jump_state_em = 1'b1;
    launch(mk_op(1, 0, MEM_SIZE_W, 0), 32'h400, 32'h0);
    n_chk++;
    if (bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_pre got %b expected 1", bus.dmem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({decoded_op_mw, rdsel_mw, next_pc_mw, alu_out_mw, jump_state_mw, mem_out_mw,
         bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, stall_memory} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs got req=%b addr=%h alu=%h rd=%0d stall=%b expected all 0",
                         bus.dmem_req, bus.dmem_addr, alu_out_mw, rdsel_mw, stall_memory);
    end
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFFFFFF;
    tick();
    bus.dmem_ack = 1'b0;
    n_chk++;
    if ({bus.dmem_req, mem_out_mw} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rstmid_idle_ack got req=%b data=%h expected 0 00000000", bus.dmem_req, mem_out_mw);
    end
    launch(mk_op(1, 0, MEM_SIZE_W, 0), 32'h404, 32'h0);
    complete(32'h12345678);
    n_chk++;
    if ({mem_out_mw, rdsel_mw, alu_out_mw} !== {32'h12345678, 5'd9, 32'h404}) begin
      n_fail++; $display("FAIL rstmid_recover got data=%h rd=%0d alu=%h expected 12345678 9 00000404",
                         mem_out_mw, rdsel_mw, alu_out_mw);
    end
  endtask

  task automatic test_back_to_back;
    int  rises;
    logic prev;
    rises = 0; prev = 1'b0;
    decoded_op_em = mk_op(1, 0, MEM_SIZE_W, 0); alu_out_em = 32'h500;
    phase_memory = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.dmem_req && !prev) rises++;
      prev = bus.dmem_req;
      bus.dmem_ack   = bus.dmem_req;
      bus.dmem_rdata = 32'hCAFEF00D;
      if (i == 4) phase_memory = 1'b0;
    end
    bus.dmem_ack = 1'b0;
    n_chk++;
    if (rises !== 1) begin n_fail++; $display("FAIL b2b_req_count got %0d expected 1", rises); end
    n_chk++;
    if (mem_out_mw !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_data got %h expected cafef00d", mem_out_mw); end
  endtask

  task automatic test_misalign;
`ifdef MISALIGN_CHECK_EN
    decoded_op_em = mk_op(1, 0, MEM_SIZE_W, 0); alu_out_em = 32'h102; phase_memory = 1'b1;
    #1;
    n_chk++;
    if (stall_memory !== 1'b0) begin n_fail++; $display("FAIL mis_stall got %b expected 0", stall_memory); end
    tick();
    phase_memory = 1'b0;
    n_chk++;
    if ({bus.dmem_req, misalign_err, mem_out_mw} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL mis_flag got req=%b err=%b data=%h expected 0 1 00000000",
                         bus.dmem_req, misalign_err, mem_out_mw);
    end
    tick();
    n_chk++;
    if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_hold got %b expected 1", misalign_err); end
    launch(mk_op(1, 0, MEM_SIZE_W, 0), 32'h100, 32'h0);
    n_chk++;
    if ({bus.dmem_req, misalign_err} !== 2'b10) begin
      n_fail++; $display("FAIL mis_clear got req=%b err=%b expected 1 0", bus.dmem_req, misalign_err);
    end
    complete(32'h11223344);
`else
    launch(mk_op(1, 0, MEM_SIZE_W, 0), 32'h102, 32'h0);
    n_chk++;
    if ({bus.dmem_req, bus.dmem_addr, bus.dmem_be} !== {1'b1, 32'h100, 4'b1111}) begin
      n_fail++; $display("FAIL mis_trunc got req=%b addr=%h be=%b expected 1 00000100 1111",
                         bus.dmem_req, bus.dmem_addr, bus.dmem_be);
    end
    complete(32'h11223344);
    n_chk++;
    if (mem_out_mw !== 32'h11223344) begin n_fail++; $display("FAIL mis_data got %h expected 11223344", mem_out_mw); end
`endif
  endtask

  initial begin
    rst = 1'b1; phase_memory = 1'b0; decoded_op_em = '0; rdsel_em = '0;
    next_pc_em = '0; alu_out_em = '0; rs2data_em = '0; jump_state_em = 1'b0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    test_reset();
    test_nonmem();
    test_store();
    test_load();
    test_reset_mid();
    test_back_to_back();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
